// File: rtl/pulse_meter.sv
// pulse_meter: measures the high time of an asynchronous pulse in clk cycles
// and flags whether it falls inside the [MINW, MAXW] acceptance window.
// Optional build macro PULSE_METER_FILTER_EN adds a 2-sample debounce stage
// between the synchronizer and the measuring FSM.
module pulse_meter #(
  parameter int CW   = 8,
  parameter int MINW = 8,
  parameter int MAXW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pin,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] width,
  output logic          match,
  output logic          ovf
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] MINV = CW'(MINW);
  localparam logic [CW-1:0] MAXV = CW'(MAXW);

  state_t        state, stateNext;
  logic          s1, s2, s3;
  logic [CW-1:0] cnt, cntNext;
  logic          sat, satNext;
  logic          busyNext, validNext, matchNext, ovfNext;
  logic [CW-1:0] widthNext;
  logic          lvl, rise;

  // Two-stage synchronizer for pin plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef PULSE_METER_FILTER_EN
  logic filt, filtNext;

  // Filtered level follows s2 only once s2 has agreed with its previous sample
  always_comb begin
    filtNext = filt;
    if (s2 == s3) filtNext = s2;
  end

  // Register the filtered level so the FSM can see its edges
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) filt <= 1'b0;
    else       filt <= filtNext;
  end

  assign lvl  = filtNext;
  assign rise = filtNext & ~filt;
`else
  assign lvl  = s2;
  assign rise = s2 & ~s3;
`endif

  // State register of the measuring FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic plus next values for the counter and result registers
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    satNext   = sat;
    busyNext  = busy;
    validNext = 1'b0;
    widthNext = width;
    matchNext = match;
    ovfNext   = ovf;
    case (state)
      IDLE: begin
        if (rise) begin
          cntNext   = CW'(1);
          satNext   = 1'b0;
          busyNext  = 1'b1;
          stateNext = MEAS;
        end
      end
      MEAS: begin
        if (lvl) begin
          if (cnt == CMAX) cntNext = CMAX;
          else             cntNext = cnt + 1'b1;
          satNext = (cntNext == CMAX);
        end else begin
          widthNext = cnt;
          ovfNext   = sat;
          matchNext = (cnt >= MINV) && (cnt <= MAXV) && !sat;
          validNext = 1'b1;
          busyNext  = 1'b0;
          satNext   = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Counter, saturation flag and held result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      sat   <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      width <= '0;
      match <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      cnt   <= cntNext;
      sat   <= satNext;
      busy  <= busyNext;
      valid <= validNext;
      width <= widthNext;
      match <= matchNext;
      ovf   <= ovfNext;
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed pulse stimulus for pulse_meter with a sample-history
// model checked every cycle, plus literal expectations after each scenario.
module tb_pulse_meter;
  localparam int CW   = 8;
  localparam int MINW = 8;
  localparam int MAXW = 12;
  localparam int WMAX = (1 << CW) - 1;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          pin  = 1'b0;
  logic          busy, valid, match, ovf;
  logic [CW-1:0] width;

  int checks   = 0;
  int failures = 0;

  // pin value sampled on each clk edge since reset release, edge 1 at index 1
  bit smp [0:2047];
  int cyc;

  // expected held results and observed statistics
  int expW;
  bit expM, expO;
  int validCount = 0;
  int busyCycles = 0;
  int lastW = 0;
  int prevW = 0;
  bit lastM, lastO;
  int t, n;
  bit expBusy, expValid;

  pulse_meter #(.CW(CW), .MINW(MINW), .MAXW(MAXW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .pin  (pin),
    .busy (busy),
    .valid(valid),
    .width(width),
    .match(match),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // hold pin at a level for n clk edges, starting just after a falling edge
  task automatic applyStimulus(input bit level, input int cycles);
    pin = level;
    repeat (cycles) @(negedge clk);
  endtask

  // number of consecutive high samples ending at edge k
  function automatic int runEnding(input int k);
    int len = 0;
    while (k >= 1 && smp[k]) begin
      len++;
      k--;
    end
    return len;
  endfunction

  // record every sampled pin value, numbered from reset release
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else begin
      if (cyc < 2046) smp[cyc+1] <= pin;
      cyc <= cyc + 1;
    end
  end

  // model: busy mirrors the sample two edges back; a report follows a
  // high-to-low sample transition two edges later and carries the run length
  always @(negedge clk) begin
    #1;
    if (!rstn) begin
      expW = 0;
      expM = 1'b0;
      expO = 1'b0;
      checkOutput("rst_busy",  int'(busy),  0);
      checkOutput("rst_valid", int'(valid), 0);
      checkOutput("rst_width", int'(width), 0);
      checkOutput("rst_match", int'(match), 0);
      checkOutput("rst_ovf",   int'(ovf),   0);
    end else begin
      t = cyc;
      expBusy  = (t >= 3) ? smp[t-2] : 1'b0;
      expValid = (t >= 4) && !smp[t-2] && smp[t-3];
      if (expValid) begin
        n    = runEnding(t - 3);
        expW = (n > WMAX) ? WMAX : n;
        expO = (n >= WMAX);
        expM = (n >= MINW) && (n <= MAXW) && !expO;
      end
      checkOutput("busy",  int'(busy),  int'(expBusy));
      checkOutput("valid", int'(valid), int'(expValid));
      checkOutput("width", int'(width), expW);
      checkOutput("match", int'(match), int'(expM));
      checkOutput("ovf",   int'(ovf),   int'(expO));
      if (busy) busyCycles++;
      if (valid) begin
        validCount++;
        prevW = lastW;
        lastW = int'(width);
        lastM = match;
        lastO = ovf;
      end
    end
  end

  int vc0;

  initial begin
    rstn = 1'b0;
    pin  = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_busy",  int'(busy),  0);
    checkOutput("reset_width", int'(width), 0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(0, 4);

    // nominal 10-cycle pulse
    busyCycles = 0;
    vc0 = validCount;
    applyStimulus(1, 10);
    applyStimulus(0, 6);
    checkOutput("p10_count", validCount - vc0, 1);
    checkOutput("p10_width", lastW, 10);
    checkOutput("p10_match", int'(lastM), 1);
    checkOutput("p10_ovf",   int'(lastO), 0);
    checkOutput("p10_busy_cycles", busyCycles, 10);

    // below and above the window, then both inclusive boundaries
    applyStimulus(1, 5);
    applyStimulus(0, 6);
    checkOutput("p5_width", lastW, 5);
    checkOutput("p5_match", int'(lastM), 0);
    applyStimulus(1, 13);
    applyStimulus(0, 6);
    checkOutput("p13_width", lastW, 13);
    checkOutput("p13_match", int'(lastM), 0);
    applyStimulus(1, 8);
    applyStimulus(0, 6);
    checkOutput("p8_match", int'(lastM), 1);
    applyStimulus(1, 12);
    applyStimulus(0, 6);
    checkOutput("p12_match", int'(lastM), 1);
    applyStimulus(1, 7);
    applyStimulus(0, 6);
    checkOutput("p7_match", int'(lastM), 0);

    // saturation, then recovery on the next pulse
    applyStimulus(1, 300);
    applyStimulus(0, 6);
    checkOutput("p300_width", lastW, 255);
    checkOutput("p300_ovf",   int'(lastO), 1);
    checkOutput("p300_match", int'(lastM), 0);
    applyStimulus(1, 9);
    applyStimulus(0, 6);
    checkOutput("p9_ovf",   int'(lastO), 0);
    checkOutput("p9_match", int'(lastM), 1);

    // back-to-back pulses separated by a single low cycle
    vc0 = validCount;
    applyStimulus(1, 4);
    applyStimulus(0, 1);
    applyStimulus(1, 6);
    applyStimulus(0, 6);
    checkOutput("b2b_count",  validCount - vc0, 2);
    checkOutput("b2b_first",  prevW, 4);
    checkOutput("b2b_second", lastW, 6);

    // shortest pulse
    applyStimulus(1, 1);
    applyStimulus(0, 6);
    checkOutput("p1_width", lastW, 1);

    // reset in the middle of a pulse aborts without a report
    vc0 = validCount;
    applyStimulus(1, 5);
    rstn = 1'b0;
    pin  = 1'b0;
    #2;
    checkOutput("abort_busy",  int'(busy),  0);
    checkOutput("abort_width", int'(width), 0);
    checkOutput("abort_match", int'(match), 0);
    checkOutput("abort_ovf",   int'(ovf),   0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    applyStimulus(0, 4);
    checkOutput("abort_no_valid", validCount - vc0, 0);
    applyStimulus(1, 9);
    applyStimulus(0, 6);
    checkOutput("after_abort_width", lastW, 9);
    checkOutput("after_abort_match", int'(lastM), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receive-side counterpart of the team's non-retriggerable monostable timer.
- Samples an asynchronous input pulse and measures its high time in clk cycles.
- Reports the width and flags whether it falls inside a tolerance window around the expected width.
- Used to check or decode pulses produced by timer blocks, or by off-chip sources.

Parameters:
CW, 8, counter/width output bits; maximum measurable width 2^CW-1
MINW, 8, minimum accepted width in cycles (inclusive)
MAXW, 12, maximum accepted width in cycles (inclusive); MINW <= MAXW < 2^CW-1 required

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
pin  input  1  asynchronous pulse input, active high
busy  output  1  high while a pulse is being measured
valid  output  1  one-cycle strobe, width/match/ovf updated this cycle
width  output  CW  last measured high time in cycles; held until next valid
match  output  1  last width within [MINW,MAXW] and no overflow; held
ovf  output  1  last pulse reached 2^CW-1 cycles (saturated); held

Behaviour:
- Reset (rstn=0, asynchronous): all flops 0.
  - Applies to sync flops s1/s2, delayed copy s3, state=IDLE, cnt=0, busy=0, valid=0, width=0, match=0, ovf=0.
- Synchronizer: s1<=pin, s2<=s1, s3<=s2. The FSM uses only s2/s3. rise = s2 & ~s3.
- FSM states:
  - IDLE:
    - On rise: cnt<=1, go to MEAS, busy<=1.
    - Otherwise remain in IDLE.
  - MEAS, s2=1: cnt<=cnt+1, saturating at 2^CW-1. Once saturated, the internal sat flag is set.
  - MEAS, s2=0 (fall): width<=cnt, ovf<=sat, match<=(MINW<=cnt<=MAXW)&~sat, valid<=1, busy<=0, sat<=0, go to IDLE.
- valid is high for exactly one cycle per measured pulse and is cleared on every other cycle.
- Width rule: a pulse sampled high on N consecutive clk edges reports width=N (N>=1).
- Latency: valid rises on the 3rd clk edge after the first edge that samples pin low (2 sync stages + 1 FSM register).
- busy rises on the 3rd edge after the first edge that samples pin high.
- Back-to-back pulses: a one-cycle low gap is resolved.
  - The report occurs on the gap edge.
  - The next rise is detected on the following edge, with no pulse lost.
- Non-retriggerable semantics mirror the timer: glitches inside MEAS do not exist at s2 granularity, since any low sample ends the measurement.
- Saturation: width stays 2^CW-1, ovf=1, match=0; the pulse is still reported on its fall.
- pin high at reset release: measured as a pulse starting at reset release (s3=0 after reset).
- Reset mid-measurement: aborts immediately, with no valid strobe; outputs read 0.

Optional Feature:
- Macro: PULSE_METER_FILTER_EN.
- Defined:
  - A 2-sample debounce stage between s2 and the FSM.
  - The filtered level changes only after s2 holds the new value for 2 consecutive edges.
  - All latencies grow by 1 cycle.
  - Single-cycle highs are ignored.
  - Single-cycle lows inside a pulse are absorbed, and the pulse width counts through them.
  - Reported width for clean pulses (>=2 cycles) is unchanged.
- Undefined: no filter; behaviour exactly as above, and 1-cycle pulses report width=1.

Test Plan:
- Reset, then pin high for 10 cycles -> one valid strobe with width=10, match=1, ovf=0, 3 cycles after pin falls; busy high for 10 cycles.
- pin high 5 cycles, then pin high 13 cycles -> width=5 match=0, then width=13 match=0; boundary pulses of 8 and 12 cycles -> match=1.
- pin high 300 cycles (CW=8) -> width=255, ovf=1, match=0; next pulse of 9 cycles -> ovf=0, match=1.
- Pulses of 4 high / 1 low / 6 high -> two valid strobes, width=4 then width=6, none missed.
- Assert rstn low at cycle 5 of a 10-cycle pulse -> no valid; busy/width/match/ovf read 0 immediately; release with pin low -> IDLE, next pulse measured normally.
- With PULSE_METER_FILTER_EN: 1-cycle pulse -> no valid; 10-cycle pulse containing one 1-cycle low -> single valid, width=10, 4 cycles after fall.
